// File: rtl/hybrid_synthesis.sv
// hybrid_synthesis: streaming MP3 IMDCT + window + overlap-add + frequency inversion, one channel.
// Ports: clk, rst (async, active-low); window_switching_flag_in, block_type_in, mixed_block_flag_in
//        (granule side info, sampled on the first sample of a granule); new_frame_start (realign to
//        sample 0); x_in/din_valid (frequency lines, subband-major); x_out/dout_valid (time samples).
module hybrid_synthesis #(
    parameter int W    = 32,
    parameter int CW   = 32,
    parameter int ACCW = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                window_switching_flag_in,
    input  logic [1:0]          block_type_in,
    input  logic                mixed_block_flag_in,
    input  logic                new_frame_start,
    input  logic signed [W-1:0] x_in,
    input  logic                din_valid,
    output logic signed [W-1:0] x_out,
    output logic                dout_valid
);
    // cos(pi*m/72) in Q2.30 for m in 0..36, Taylor series in 64-bit fixed point.
    function automatic longint cosq(input int m);
        longint a, x2, term, sum;
        a = (longint'(m) * 64'sd3373259426) / 72;
        x2 = (a * a) >>> 30;
        term = 64'sd1 << 30;
        sum = term;
        for (int i = 1; i < 13; i++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i)));
            sum = sum + term;
        end
        return sum;
    endfunction

    // cos(pi*m/72) for any integer m, folded onto the first quadrant.
    function automatic longint cosk(input int m);
        int r;
        r = m % 144;
        if (r < 0) r = r + 144;
        if (r > 72) r = 144 - r;
        return (r > 36) ? -cosq(72 - r) : cosq(r);
    endfunction

    function automatic longint sink(input int m);
        return cosk(36 - m);
    endfunction

    // Window folded into the IMDCT cosine; every angle is a multiple of pi/72.
    function automatic longint coef(input int t, input int n, input int j);
        longint win, c;
        int w, i;
        c = 0;
        if (t == 2) begin
            w = n % 3;
            if (j >= 6 + 6 * w && j < 18 + 6 * w) begin
                i = j - 6 - 6 * w;
                c = (sink(6 * i + 3) * cosk(3 * (2 * i + 7) * (2 * (n / 3) + 1))) >>> 30;
            end
        end else begin
            if (t == 1)
                win = (j < 18) ? sink(2 * j + 1) : (j < 24) ? (64'sd1 << 30) :
                      (j < 30) ? sink(6 * j - 105) : 64'sd0;
            else if (t == 3)
                win = (j < 6) ? 64'sd0 : (j < 12) ? sink(6 * j - 33) :
                      (j < 18) ? (64'sd1 << 30) : sink(2 * j + 1);
            else
                win = sink(2 * j + 1);
            c = (win * cosk((2 * j + 19) * (2 * n + 1))) >>> 30;
        end
        return c;
    endfunction

    logic signed [CW-1:0] coef_tab [4][18][36];

    for (genvar t = 0; t < 4; t++) begin : g_t
        for (genvar n = 0; n < 18; n++) begin : g_n
            for (genvar j = 0; j < 36; j++) begin : g_j
                localparam logic signed [CW-1:0] C = CW'(coef(t, n, j));
                assign coef_tab[t][n][j] = C;
            end
        end
    end

    logic [4:0]             n_q, s_q, i_q, zs_q;
    logic                   ws_q, mixed_q, busy_q, dout_valid_q;
    logic [1:0]             bt_q;
    logic [31:0]            primed_q;
    logic signed [W-1:0]    x_out_q;
    logic signed [ACCW-1:0] acc_q [36];
    logic signed [ACCW-1:0] acc_d [36];
    logic [W-1:0]           z_q [36];
    logic [W-1:0]           ovl_mem [576];
    logic                   first, last, cur_ws, cur_mx;
    logic [1:0]             cur_bt, typ;
    logic [9:0]             ovl_addr;
    logic [W-1:0]           ovl_rd, y, x_out_d;

    // Side info of the granule's first sample applies to that sample already.
    assign first  = (n_q == 5'd0) && (s_q == 5'd0);
    assign last   = (n_q == 5'd17);
    assign cur_ws = first ? window_switching_flag_in : ws_q;
    assign cur_mx = first ? mixed_block_flag_in : mixed_q;
    assign cur_bt = first ? block_type_in : bt_q;
    assign typ    = !cur_ws ? 2'd0 : (cur_mx && s_q < 5'd2) ? 2'd0 : cur_bt;

    always_comb begin
        for (int j = 0; j < 36; j++)
            acc_d[j] = ((n_q == 5'd0) ? '0 : acc_q[j]) +
                       ACCW'(((W+CW)'(x_in) * (W+CW)'(coef_tab[typ][n_q][j])) >>> 30);
    end

    assign ovl_addr = 10'(zs_q) * 10'd18 + 10'(i_q);
    assign ovl_rd   = primed_q[zs_q] ? ovl_mem[ovl_addr] : '0;
    assign y        = z_q[6'(i_q)] + ovl_rd;
    assign x_out_d  = (zs_q[0] && i_q[0]) ? -y : y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q          <= '0;
            s_q          <= '0;
            i_q          <= '0;
            zs_q         <= '0;
            ws_q         <= 1'b0;
            mixed_q      <= 1'b0;
            bt_q         <= '0;
            busy_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            x_out_q      <= '0;
            primed_q     <= '0;
            for (int j = 0; j < 36; j++) begin
                acc_q[j] <= '0;
                z_q[j]   <= '0;
            end
        end else begin
            dout_valid_q <= busy_q;
            if (busy_q) begin
                x_out_q <= x_out_d;
                i_q     <= i_q + 5'd1;
                if (i_q == 5'd17) begin
                    busy_q          <= 1'b0;
                    primed_q[zs_q]  <= 1'b1;
                end
            end
            if (new_frame_start) begin
                n_q <= '0;
                s_q <= '0;
            end else if (din_valid) begin
                n_q <= last ? 5'd0 : n_q + 5'd1;
                if (last) s_q <= s_q + 5'd1;
                if (first) begin
                    ws_q    <= window_switching_flag_in;
                    bt_q    <= block_type_in;
                    mixed_q <= mixed_block_flag_in;
                end
                for (int j = 0; j < 36; j++) acc_q[j] <= acc_d[j];
                // Snapshot frees the accumulators for the next subband at full rate.
                if (last) begin
                    for (int j = 0; j < 36; j++) z_q[j] <= W'(acc_d[j]);
                    busy_q <= 1'b1;
                    i_q    <= '0;
                    zs_q   <= s_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (busy_q) ovl_mem[ovl_addr] <= z_q[6'(i_q) + 6'd18];
    end

    assign x_out      = x_out_q;
    assign dout_valid = dout_valid_q;
endmodule

// File: tb/tb_hybrid_synthesis.sv
// tb_hybrid_synthesis: directed-vector bench for hybrid_synthesis.
module tb_hybrid_synthesis;
    localparam int W = 32;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0, rst = 1'b0, wsf = 1'b0, mbf = 1'b0, nfs = 1'b0, din_valid = 1'b0;
    logic [1:0] bt = 2'd0;
    logic signed [W-1:0] x_in = '0;
    logic signed [W-1:0] x_out;
    logic dout_valid;
    int checks = 0, errors = 0, cyc = 0, out_cnt = 0, first_cyc = -1, t18 = 0;
    int outs [0:1023];

    hybrid_synthesis dut (
        .clk(clk), .rst(rst), .window_switching_flag_in(wsf), .block_type_in(bt),
        .mixed_block_flag_in(mbf), .new_frame_start(nfs), .x_in(x_in), .din_valid(din_valid),
        .x_out(x_out), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid) begin
            if (out_cnt == 0) first_cyc = cyc;
            if (out_cnt < 1024) outs[out_cnt] = x_out;
            out_cnt++;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        checks++;
        if ((got > exp ? got - exp : exp - got) > tol) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Long-block (type 0) response at lane j to an impulse of 2^19 at n=0.
    function automatic int lx(input int j);
        return $rtoi(524288.0 * $sin(PI / 36.0 * (j + 0.5)) * $cos(PI / 72.0 * (2 * j + 19)));
    endfunction

    // Short-block response at lane 6+i to an impulse of 2^19 at n=0.
    function automatic int sx(input int i);
        return $rtoi(524288.0 * $sin(PI / 12.0 * (i + 0.5)) * $cos(PI / 24.0 * (2 * i + 7)));
    endfunction

    function automatic int nz(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) if (outs[k] != 0) c++;
        return c;
    endfunction

    task automatic feed(input int imp, input bit ws, input logic [1:0] t, input bit mx,
                        input bit gaps, input int len, input int nfs_at);
        for (int k = 0; k < len; k++) begin
            if (gaps && k % 5 == 4) begin
                @(negedge clk);
                din_valid = 1'b0;
            end
            @(negedge clk);
            din_valid = 1'b1;
            x_in = (k == imp) ? 32'sd524288 : 32'sd0;
            nfs = (k == nfs_at);
            wsf = ws;
            bt = t;
            mbf = mx;
            if (k == 17) t18 = cyc;
        end
        @(negedge clk);
        din_valid = 1'b0;
        nfs = 1'b0;
        x_in = '0;
    endtask

    task automatic settle();
        repeat (25) @(negedge clk);
    endtask

    initial begin
        repeat (3) begin
            @(negedge clk);
            din_valid = ~din_valid;
            nfs = ~nfs;
            x_in = $urandom;
        end
        check("rst_valid_a", dout_valid, 0, 0);
        check("rst_xout_a", x_out, 0, 0);
        repeat (4) begin
            @(negedge clk);
            din_valid = ~din_valid;
            x_in = $urandom;
        end
        check("rst_valid_b", dout_valid, 0, 0);
        check("rst_xout_b", x_out, 0, 0);
        @(negedge clk);
        din_valid = 1'b0;
        nfs = 1'b0;
        x_in = '0;
        rst = 1'b1;
        out_cnt = 0;
        repeat (17) begin
            @(negedge clk);
            din_valid = 1'b1;
            x_in = 32'sd524288;
        end
        @(negedge clk);
        din_valid = 1'b0;
        x_in = '0;
        nfs = 1'b1;
        @(negedge clk);
        nfs = 1'b0;
        settle();
        check("partial_no_out", out_cnt, 0, 0);
        check("idle_xout", x_out, 0, 0);

        out_cnt = 0;
        first_cyc = -1;
        feed(-1, 0, 2'd0, 0, 0, 576, -1);
        settle();
        check("zero_count", out_cnt, 576, 0);
        check("zero_values", nz(0, 575), 0, 0);
        check("first_latency", first_cyc - t18, 2, 0);

        out_cnt = 0;
        feed(0, 0, 2'd0, 0, 0, 576, -1);
        settle();
        check("long_out0", outs[0], 15451, 2);
        check("long_out9", outs[9], lx(9), 2);
        check("long_out17", outs[17], lx(17), 2);
        check("long_other_sb", nz(18, 575), 0, 0);

        out_cnt = 0;
        feed(-1, 0, 2'd0, 0, 1, 576, -1);
        settle();
        check("gap_count", out_cnt, 576, 0);
        check("ovl_out0", outs[0], lx(18), 2);
        check("ovl_out17", outs[17], lx(35), 2);
        check("ovl_other_sb", nz(18, 575), 0, 0);

        out_cnt = 0;
        feed(0, 1, 2'd2, 0, 0, 576, -1);
        settle();
        check("short_out0", outs[0], 0, 0);
        check("short_out5", outs[5], 0, 0);
        check("short_out6", outs[6], sx(0), 2);
        check("short_out17", outs[17], sx(11), 2);

        out_cnt = 0;
        feed(0, 1, 2'd2, 1, 0, 576, -1);
        settle();
        check("mixed_out0", outs[0], 15451, 2);

        out_cnt = 0;
        feed(18, 0, 2'd0, 0, 0, 576, -1);
        settle();
        check("inv_out0", outs[18], 15451, 2);
        check("inv_out1", outs[19], -lx(1), 2);
        check("inv_out2", outs[20], lx(2), 2);
        check("inv_out17", outs[35], -lx(17), 2);

        out_cnt = 0;
        feed(0, 0, 2'd0, 0, 0, 98, 97);
        feed(-1, 0, 2'd0, 0, 0, 576, -1);
        settle();
        check("nfs_count", out_cnt, 666, 0);
        check("nfs_pre_out0", outs[0], 15451, 2);
        check("nfs_ovl_out0", outs[90], lx(18), 2);
        check("nfs_ovl_out17", outs[107], lx(35), 2);

        feed(0, 0, 2'd0, 0, 0, 18, -1);
        repeat (3) @(negedge clk);
        check("burst_active", dout_valid, 1, 0);
        rst = 1'b0;
        #1;
        check("abort_valid", dout_valid, 0, 0);
        check("abort_xout", x_out, 0, 0);
        out_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        settle();
        check("abort_no_out", out_cnt, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
